// File: rtl/hybrid_control_pipe_pkg.sv
// Shared widths, encodings and constants for the pipelined half/quarter-plane
// hybrid controller of the resonant converter.
package hybrid_pkg;

  typedef enum logic {MODE_QUARTER = 1'b0, MODE_HALF = 1'b1} mode_e;
  typedef enum logic {SIGMA_0 = 1'b0, SIGMA_1 = 1'b1} sigma_e;

  localparam int DEBUG_OFFSET = 8191;
  localparam int ONE          = 16384;

  function automatic int z_width(input int data_w, input int coef_w);
    return data_w + coef_w + 1;
  endfunction

  function automatic int j_width(input int z_w, input int trig_w);
    return z_w + trig_w + 2;
  endfunction

endpackage

// File: rtl/hybrid_control_pipe_if.sv
// Sample/decision bundle between the ADC front-end, the controller and the
// gate-drive block.
interface hybrid_control_pipe_if #(
  parameter int DATA_W  = 14,
  parameter int TRIG_W  = 16,
  parameter int DWELL_W = 16
);
  logic                      i_valid;
  logic signed [DATA_W-1:0]  i_vC;
  logic signed [DATA_W-1:0]  i_iC;
  logic signed [TRIG_W-1:0]  i_cos;
  logic signed [TRIG_W-1:0]  i_sin;
  logic                      i_mode;
  logic        [DWELL_W-1:0] i_min_dwell;
  logic                      o_sigma;
  logic                      o_switch;
  logic                      o_valid;
  logic        [13:0]        o_debug;

  modport master (
    output i_valid, i_vC, i_iC, i_cos, i_sin, i_mode, i_min_dwell,
    input  o_sigma, o_switch, o_valid, o_debug
  );

  modport slave (
    input  i_valid, i_vC, i_iC, i_cos, i_sin, i_mode, i_min_dwell,
    output o_sigma, o_switch, o_valid, o_debug
  );
endinterface

// File: rtl/hybrid_control_pipe_jump_eval.sv
// Stages 2-3: registered rotation products, then combinational j1/j2 and the
// jump flag for the sigma decision; valid and tag ride along.
module hybrid_jump_eval
  import hybrid_pkg::*;
#(
  parameter int Z_W    = 33,
  parameter int TRIG_W = 16,
  parameter int J_W    = 51
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vld_i,
  input  logic                     tag_i,
  input  mode_e                    mode_i,
  input  logic signed [Z_W-1:0]    z1_i,
  input  logic signed [Z_W-1:0]    z2_i,
  input  logic signed [TRIG_W-1:0] cos_i,
  input  logic signed [TRIG_W-1:0] sin_i,
  output logic                     vld_o,
  output logic                     tag_o,
  output logic                     jump_o,
  output logic [13:0]              j1_dbg_o
);
  localparam int P_W = Z_W + TRIG_W;
  localparam logic signed [J_W-1:0] J_ZERO = '0;

  logic                  vld_q, tag_q;
  mode_e                 mode_q;
  logic signed [P_W-1:0] p_sc_q, p_cc_q, q_c_q, q_s_q;
  logic signed [J_W-1:0] sum1, sum2, j1, j2;
  logic                  j1_neg, j2_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      tag_q  <= 1'b1;
      mode_q <= MODE_QUARTER;
      p_sc_q <= '0;
      p_cc_q <= '0;
      q_c_q  <= '0;
      q_s_q  <= '0;
    end else begin
      vld_q <= vld_i;
      if (vld_i) begin
        tag_q  <= tag_i;
        mode_q <= mode_i;
        p_sc_q <= P_W'(z1_i) * P_W'(sin_i);
        p_cc_q <= P_W'(z1_i) * P_W'(cos_i);
        q_c_q  <= P_W'(z2_i) * P_W'(cos_i);
        q_s_q  <= P_W'(z2_i) * P_W'(sin_i);
      end
    end
  end

  // The sign flip uses the tag, i.e. the sigma this sample was taken under.
  assign sum1   = J_W'(p_sc_q) + J_W'(q_c_q);
  assign sum2   = J_W'(q_s_q) - J_W'(p_cc_q);
  assign j1     = tag_q ? -sum1 : sum1;
  assign j2     = tag_q ? -sum2 : sum2;
  assign j1_neg = j1 < J_ZERO;
  assign j2_neg = j2 < J_ZERO;

  assign vld_o    = vld_q;
  assign tag_o    = tag_q;
  assign jump_o   = j1_neg && ((mode_q == MODE_HALF) || j2_neg);
  assign j1_dbg_o = {j1_neg, j1[22:10]};

endmodule

// File: rtl/hybrid_control_pipe.sv
// Pipelined hybrid controller top: stage-1 jump-set coordinates, sigma/dwell
// decision and the offset-binary debug DAC word.
module hybrid_control_pipe
  import hybrid_pkg::*;
#(
  parameter int DATA_W  = 14,
  parameter int TRIG_W  = 16,
  parameter int COEF_W  = 18,
  parameter int MU_Z1   = 110,
  parameter int MU_Z2   = 25,
  parameter int VG      = 24000,
  parameter int DWELL_W = 16
) (
  input  logic                  i_clock,
  input  logic                  i_RESET,
  hybrid_control_pipe_if.slave  bus
);
  localparam int Z_W = z_width(DATA_W, COEF_W);
  localparam int J_W = j_width(Z_W, TRIG_W);

  localparam logic signed [COEF_W-1:0] MU1_C = COEF_W'(MU_Z1);
  localparam logic signed [COEF_W-1:0] MU2_C = COEF_W'(MU_Z2);
  localparam logic signed [COEF_W-1:0] VG_C  = COEF_W'(VG);

  logic signed [Z_W-1:0]    mu1_x, mu2_x, vg_x, vc_x, ic_x, z1_d, z2_d;
  logic signed [Z_W-1:0]    z1_q, z2_q;
  logic signed [TRIG_W-1:0] cos_q, sin_q;
  logic                     s1_vld_q, tag_q;
  mode_e                    mode_q;

  sigma_e               sigma_q;
  logic                 switch_q, ovld_q;
  logic [13:0]          debug_q;
  logic [DWELL_W-1:0]   dwell_q;

  logic                 s2_vld, s2_tag, jump;
  logic [13:0]          j1_dbg;

  assign mu1_x = Z_W'(MU1_C);
  assign mu2_x = Z_W'(MU2_C);
  assign vg_x  = Z_W'(VG_C);
  assign vc_x  = Z_W'(bus.i_vC);
  assign ic_x  = Z_W'(bus.i_iC);

  // sigma = 1 means s = -1, so the supply offset is subtracted.
  assign z1_d = mu1_x * vc_x + ((sigma_q == SIGMA_1) ? -vg_x : vg_x);
  assign z2_d = mu2_x * ic_x;

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      s1_vld_q <= 1'b0;
      tag_q    <= 1'b1;
      mode_q   <= MODE_QUARTER;
      z1_q     <= '0;
      z2_q     <= '0;
      cos_q    <= '0;
      sin_q    <= '0;
    end else begin
      s1_vld_q <= bus.i_valid;
      if (bus.i_valid) begin
        tag_q  <= sigma_q;
        mode_q <= mode_e'(bus.i_mode);
        z1_q   <= z1_d;
        z2_q   <= z2_d;
        cos_q  <= bus.i_cos;
        sin_q  <= bus.i_sin;
      end
    end
  end

  hybrid_jump_eval #(
    .Z_W    (Z_W),
    .TRIG_W (TRIG_W),
    .J_W    (J_W)
  ) u_eval (
    .clk      (i_clock),
    .rst_n    (i_RESET),
    .vld_i    (s1_vld_q),
    .tag_i    (tag_q),
    .mode_i   (mode_q),
    .z1_i     (z1_q),
    .z2_i     (z2_q),
    .cos_i    (cos_q),
    .sin_i    (sin_q),
    .vld_o    (s2_vld),
    .tag_o    (s2_tag),
    .jump_o   (jump),
    .j1_dbg_o (j1_dbg)
  );

  // Samples tagged with a superseded sigma are stale: they refresh the debug
  // word but never switch.
  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      sigma_q  <= SIGMA_1;
      switch_q <= 1'b0;
      ovld_q   <= 1'b0;
      debug_q  <= 14'(DEBUG_OFFSET);
      dwell_q  <= '0;
    end else begin
      switch_q <= 1'b0;
      ovld_q   <= s2_vld;
      if (dwell_q != '0) dwell_q <= dwell_q - DWELL_W'(1);
      if (s2_vld) begin
        debug_q <= j1_dbg + 14'(DEBUG_OFFSET);
        if (jump && (s2_tag == sigma_q) && (dwell_q == '0)) begin
          sigma_q  <= (sigma_q == SIGMA_1) ? SIGMA_0 : SIGMA_1;
          switch_q <= 1'b1;
          dwell_q  <= bus.i_min_dwell;
        end
      end
    end
  end

  assign bus.o_sigma  = sigma_q;
  assign bus.o_switch = switch_q;
  assign bus.o_valid  = ovld_q;
  assign bus.o_debug  = debug_q;

endmodule

// File: doc/hybrid_control_pipe.md
Name: hybrid_control_pipe

Overview:
Parametrised, pipelined successor of the half-plane hybrid controller for the resonant converter.
- Computes the jump-set coordinates from capacitor voltage and current samples plus externally supplied cos/sin of theta.
- Toggles the switching state sigma when the trajectory enters the jump set.
- Adds over the previous generation: selectable jump-set shape, minimum dwell time between switchings, sample-valid handshake, discard of stale in-flight samples, and a switch-event pulse.
- Sits between the ADC front-end and the gate-drive/dead-time block.

Parameters:
- DATA_W, 14: signed width of i_vC, i_iC.
- TRIG_W, 16: signed width of i_cos, i_sin (Q1.14, 16384 = 1.0).
- COEF_W, 18: signed width of MU_Z1, MU_Z2, VG.
- MU_Z1, 110: voltage multiplier.
- MU_Z2, 25: current multiplier.
- VG, 24000: supply offset added to z1.
- DWELL_W, 16: width of the dwell counter.

Ports:
- i_clock, in, 1: system clock.
- i_RESET, in, 1: asynchronous, active-low reset.
- i_valid, in, 1: sample strobe; i_vC, i_iC, i_cos, i_sin are sampled when high.
- i_vC, in, DATA_W: signed capacitor voltage.
- i_iC, in, DATA_W: signed capacitor current.
- i_cos, in, TRIG_W: signed cos(theta).
- i_sin, in, TRIG_W: signed sin(theta).
- i_mode, in, 1: 0 = quarter-plane jump set, 1 = half-plane jump set (j1 only).
- i_min_dwell, in, DWELL_W: minimum cycles between switchings, unsigned.
- o_sigma, out, 1: switching state.
- o_switch, out, 1: one-cycle pulse on every sigma toggle.
- o_valid, out, 1: stage-3 decision valid (debug).
- o_debug, out, 14: {j1 sign, j1[22:10]} + 8191, offset-binary for the DAC.

Behaviour:
Reset (i_RESET low, asynchronous):
- o_sigma = 1; o_switch = 0; o_valid = 0; o_debug = 8191.
- All pipeline valid bits = 0; dwell counter = 0, i.e. switching allowed.

Sign convention:
- s = -1 when sigma = 1; s = +1 when sigma = 0.

Stage 1 (registered on the i_valid cycle):
- z1 = MU_Z1*vC + s*VG; z2 = MU_Z2*iC.
- Also register cos, sin, i_mode, and tag = current sigma.
- Internal width Z_W = DATA_W + COEF_W + 1. Full precision, no saturation.

Stage 2:
- Register p_sc = z1*sin, p_cc = z1*cos, q_c = z2*cos, q_s = z2*sin.
- Width Z_W + TRIG_W.

Stage 3:
- j1 = s*(p_sc + q_c); j2 = s*(q_s - p_cc), where s is taken from the tag.
- Width Z_W + TRIG_W + 2.
- o_valid = stage-3 valid.

Jump condition:
- jump = (j1 < 0) && (j2 < 0) when mode = 0; jump = (j1 < 0) when mode = 1.
- Zero is not negative: no jump on zero.

Switch decision, evaluated on the stage-3 valid cycle:
- Sigma toggles when jump && tag == o_sigma && dwell counter == 0.
- Latency from i_valid to o_sigma change: 3 clock edges.
- On a toggle: o_switch = 1 for exactly one cycle; dwell counter loads i_min_dwell.

Dwell counter:
- Decrements every cycle while nonzero; saturates at 0.
- i_min_dwell = 0 means no dwell limit.

Stale samples:
- Any in-flight sample with tag != o_sigma is dropped: no toggle, no o_switch.
- o_debug still updates from it.

Other rules:
- Back-to-back i_valid every cycle is supported; there is no stall and no backpressure.
- If i_valid is low, its valid bit propagates as 0. Registers hold their values except the valid bits.
- i_mode and theta are per-sample (carried in the pipeline); i_min_dwell is sampled at the toggle.
- o_debug updates only on stage-3 valid: two's-complement {j1 sign, j1[22:10]} + 14'd8191, wrapping.
- Reset asserted mid-operation clears all state immediately. The first decision after reset release needs a fresh i_valid.

Decomposition:
- Package hybrid_pkg holds:
  - derived width functions (Z_W, J_W);
  - mode encodings MODE_QUARTER = 0, MODE_HALF = 1;
  - DEBUG_OFFSET = 8191;
  - Q1.14 ONE = 16384.
- One natural sub-module, hybrid_jump_eval: stages 2–3, i.e. products, j1/j2 and the jump flag, with a valid/tag passthrough.
- The top level holds stage 1, the sigma/dwell FSM and the debug output.

Test Plan:
1. Reset, then quarter mode, cos=16384, sin=0, vC=100, iC=50, one i_valid pulse.
   - z1 = 11000 - 24000 < 0 and z2 > 0 give j1 < 0, j2 < 0.
   - Required: o_sigma goes 1→0 exactly 3 edges after i_valid; o_switch high for 1 cycle.
2. Continue with the same inputs, sigma = 0.
   - z1 = 35000 gives j1 > 0.
   - Required: no further toggle over 20 samples.
3. Quarter vs half mode with sigma = 1, theta = 0, vC=300, iC=50.
   - z1 > 0 gives j2 > 0 and j1 < 0.
   - Required: mode 0 gives no toggle; mode 1 toggles.
4. Dwell: i_min_dwell=10, alternating jump-inducing samples every cycle.
   - Required: consecutive o_switch pulses at least 10 cycles apart.
   - Required: with i_min_dwell=0, stale-tag samples in flight never produce an extra toggle.
5. Boundary: choose inputs giving j1 = 0 exactly (iC=0, theta=0).
   - Required: no toggle.
   - Required: o_debug = 8191 when j1 = 0.
6. Reset mid-pipeline: assert i_RESET low one cycle after a jump-inducing i_valid.
   - Required: o_sigma = 1, o_switch = 0, o_valid = 0 immediately and after release.
   - Required: no delayed toggle.
